// File: rtl/aes_pkg.sv
// Shared AES-128 types, S-box, round-constant table and column/byte helpers
// used by the iterative core and its key schedule.
package aes_pkg;

    typedef logic [3:0][3:0][7:0] state_t;

    localparam logic [3:0] DCNT_START = 4'hb;

    // S-box row-major, entry 0 in the top byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] base;
        base = {~b, 3'b000};
        return SBOX_TBL[base +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] rc;
        case (idx)
            4'd0:    rc = 8'h01;
            4'd1:    rc = 8'h02;
            4'd2:    rc = 8'h04;
            4'd3:    rc = 8'h08;
            4'd4:    rc = 8'h10;
            4'd5:    rc = 8'h20;
            4'd6:    rc = 8'h40;
            4'd7:    rc = 8'h80;
            4'd8:    rc = 8'h1b;
            4'd9:    rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // SubBytes followed by ShiftRows; byte r+4c sits at bits 127-8(r+4c).
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] s);
        logic [127:0] o;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            o[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes128_key_sched.sv
// On-the-fly AES-128 key expander: presents the current round key and
// advances to the next one every cycle that is not a load.
module aes128_key_sched
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic [127:0] key,
    output logic [127:0] rk
);

    logic [31:0] w0_r, w1_r, w2_r, w3_r;
    logic [3:0]  rcon_idx_r;
    logic [31:0] t_s, n0_s, n1_s, n2_s, n3_s;

    // Next round key from RotWord/SubWord of the last word plus rcon.
    always_comb begin
        t_s  = {sbox(w3_r[23:16]), sbox(w3_r[15:8]), sbox(w3_r[7:0]), sbox(w3_r[31:24])}
             ^ {rcon(rcon_idx_r), 24'h000000};
        n0_s = w0_r ^ t_s;
        n1_s = w1_r ^ n0_s;
        n2_s = w2_r ^ n1_s;
        n3_s = w3_r ^ n2_s;
    end

    // Key word registers: load on ld, otherwise step one round.
    always_ff @(posedge clk) begin
        if (!rst) begin
            {w0_r, w1_r, w2_r, w3_r} <= 128'h0;
            rcon_idx_r               <= 4'd0;
        end else if (ld) begin
            {w0_r, w1_r, w2_r, w3_r} <= key;
            rcon_idx_r               <= 4'd0;
        end else begin
            {w0_r, w1_r, w2_r, w3_r} <= {n0_s, n1_s, n2_s, n3_s};
            rcon_idx_r               <= rcon_idx_r + 4'd1;
        end
    end

    assign rk = {w0_r, w1_r, w2_r, w3_r};

endmodule

// File: rtl/aes128_iter_core.sv
// Iterative AES-128 encryption core, one round per clock; ciphertext is
// presented on text_out together with a one-cycle done strobe.
module aes128_iter_core
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic [127:0] key,
    input  logic [127:0] text_in,
    output logic [127:0] text_out,
    output logic         done,
    output logic [127:0] state,
    output logic [3:0]   dcnt
);

    logic [127:0] rk_s;
    logic [127:0] sub_shift_s;
    logic [127:0] next_state_s;
    logic [127:0] final_s;
    logic [127:0] text_in_r;
    logic [127:0] text_out_r;
    state_t       state_r;
    logic         ld_r;
    logic         done_r;
    logic [3:0]   dcnt_r;

    aes128_key_sched u_key_sched (
        .clk (clk),
        .rst (rst),
        .ld  (ld),
        .key (key),
        .rk  (rk_s)
    );

    // Round datapath: initial AddRoundKey right after a load, full round otherwise.
    always_comb begin
        sub_shift_s = sub_shift(state_r);
        final_s     = sub_shift_s ^ rk_s;
        if (ld_r) begin
            next_state_s = text_in_r ^ rk_s;
        end else begin
            next_state_s = mix_cols(sub_shift_s) ^ rk_s;
        end
    end

    // State, output and control registers; done is suppressed by a coincident ld.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ld_r       <= 1'b0;
            text_in_r  <= 128'h0;
            state_r    <= '0;
            text_out_r <= 128'h0;
            done_r     <= 1'b0;
            dcnt_r     <= 4'd0;
        end else begin
            ld_r       <= ld;
            text_in_r  <= ld ? text_in : text_in_r;
            state_r    <= next_state_s;
            text_out_r <= final_s;
            done_r     <= (dcnt_r == 4'd1) && !ld;
            if (ld) begin
                dcnt_r <= DCNT_START;
            end else if (dcnt_r != 4'd0) begin
                dcnt_r <= dcnt_r - 4'd1;
            end else begin
                dcnt_r <= dcnt_r;
            end
        end
    end

    assign text_out = text_out_r;
    assign done     = done_r;
    assign state    = state_r;
    assign dcnt     = dcnt_r;

endmodule

// File: tb/tb_aes128_iter_core.sv
// Directed and randomized bench for aes128_iter_core against a byte-level
// AES-128 model whose S-box is derived from GF(2^8) inversion.
module tb_aes128_iter_core;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         ld = 1'b0;
    logic [127:0] key = 128'h0;
    logic [127:0] text_in = 128'h0;
    logic [127:0] text_out;
    logic         done;
    logic [127:0] state;
    logic [3:0]   dcnt;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] sb_tab [256];

    aes128_iter_core dut (
        .clk      (clk),
        .rst      (rst),
        .ld       (ld),
        .key      (key),
        .text_in  (text_in),
        .text_out (text_out),
        .done     (done),
        .state    (state),
        .dcnt     (dcnt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        logic hi;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
            b  = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [127:0] ref_encrypt(input logic [127:0] k, input logic [127:0] p);
        logic [7:0] rk [176];
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] tmp [4];
        logic [7:0] rc, x;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) begin
            rk[i] = k[127-8*i -: 8];
            s[i]  = p[127-8*i -: 8];
        end
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) tmp[j] = rk[4*(i-1)+j];
            if (i % 4 == 0) begin
                x      = tmp[0];
                tmp[0] = sb_tab[tmp[1]] ^ rc;
                tmp[1] = sb_tab[tmp[2]];
                tmp[2] = sb_tab[tmp[3]];
                tmp[3] = sb_tab[x];
                rc     = gmul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) rk[4*i+j] = rk[4*(i-4)+j] ^ tmp[j];
        end
        for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[i];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sb_tab[s[(i%4) + 4*(((i/4) + (i%4)) % 4)]];
            for (int c = 0; c < 4; c++) begin
                if (r != 10) begin
                    s[4*c+0] = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
                    s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
                end else begin
                    for (int j = 0; j < 4; j++) s[4*c+j] = t[4*c+j];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[16*r+i];
        end
        o = 128'h0;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [127:0] k, input logic [127:0] p);
        key = k; text_in = p; ld = 1'b1;
        @(negedge clk);
        ld = 1'b0; key = rand128(); text_in = rand128();
        check("start_dcnt", {124'h0, dcnt}, {124'h0, 4'hb});
        check("start_done", {127'h0, done}, 128'h0);
    endtask

    task automatic advance(input int from_k, input int n);
        logic [3:0] ed;
        for (int k = from_k; k < from_k + n; k++) begin
            @(negedge clk);
            ed = 4'd11 - 4'(k);
            check("run_dcnt", {124'h0, dcnt}, {124'h0, ed});
            check("run_done", {127'h0, done}, 128'h0);
        end
    endtask

    task automatic follow(input logic [127:0] exp_ct, input logic [127:0] exp_s1, input string tag);
        advance(1, 1);
        check({tag, "_state_e1"}, state, exp_s1);
        advance(2, 9);
        @(negedge clk);
        check({tag, "_done"}, {127'h0, done}, {127'h0, 1'b1});
        check({tag, "_dcnt0"}, {124'h0, dcnt}, 128'h0);
        check({tag, "_ct"}, text_out, exp_ct);
    endtask

    localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] S1_B  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] C_Z   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    initial begin
        logic [7:0] inv, xb;
        logic [127:0] rk, rp;
        for (int x = 0; x < 256; x++) begin
            xb  = x[7:0];
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(xb, y[7:0]) == 8'h01) inv = y[7:0];
            end
            sb_tab[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                      ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end

        // reset state
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_dcnt", {124'h0, dcnt}, 128'h0);
        check("rst_done", {127'h0, done}, 128'h0);
        check("rst_text_out", text_out, 128'h0);
        check("rst_state", state, 128'h0);
        rst = 1'b1;
        @(negedge clk);

        // FIPS-197 C.1, then B and all-zero back-to-back
        start(K_C1, P_C1);
        follow(C_C1, K_C1 ^ P_C1, "c1");
        start(K_B, P_B);
        follow(C_B, S1_B, "fips_b");
        start(128'h0, 128'h0);
        follow(C_Z, 128'h0, "zero");
        check("model_c1", ref_encrypt(K_C1, P_C1), C_C1);

        // restart with B at dcnt=5 of a C.1 run
        @(negedge clk);
        start(K_C1, P_C1);
        advance(1, 6);
        start(K_B, P_B);
        follow(C_B, S1_B, "restart");

        // ld coinciding with dcnt==1 suppresses done
        start(128'h0, 128'h0);
        advance(1, 10);
        start(K_B, P_B);
        follow(C_B, S1_B, "ld_at_1");

        // reset mid-operation at dcnt=3
        start(K_C1, P_C1);
        advance(1, 8);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_dcnt", {124'h0, dcnt}, 128'h0);
        check("mid_rst_done", {127'h0, done}, 128'h0);
        check("mid_rst_text_out", text_out, 128'h0);
        check("mid_rst_state", state, 128'h0);
        rst = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            check("post_rst_done", {127'h0, done}, 128'h0);
            check("post_rst_dcnt", {124'h0, dcnt}, 128'h0);
        end

        // random vectors, back-to-back
        for (int n = 0; n < 6; n++) begin
            rk = rand128();
            rp = rand128();
            start(rk, rp);
            follow(ref_encrypt(rk, rp), rk ^ rp, "rand");
        end

        @(negedge clk);
        check("final_done_low", {127'h0, done}, 128'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/aes128_iter_core.md
# aes128_iter_core

Iterative AES-128 encryption core with one round per clock. It contains the on-the-fly key expander, 16 S-box lookups, ShiftRows, MixColumns and AddRoundKey datapath, plus a round counter and a done strobe. It sits below the bus/wrapper layer, which supplies key and plaintext with a load pulse and collects ciphertext on `done`.

## Interface
- No parameters. AES-128 only, 10 rounds fixed.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `ld` in 1: start pulse; samples `key` and `text_in`.
- `key` in 128: cipher key, FIPS-197 byte order (byte 0 = bits 127:120).
- `text_in` in 128: plaintext, same byte order.
- `text_out` out 128: ciphertext, valid while `done`=1.
- `done` out 1: one-cycle strobe.
- `state` out 128: current state register sa[r][c] for debug; byte r+4c is at bits 127-8(4c+r) -: 8.
- `dcnt` out 4: round down-counter for debug.

## Operation
- State is a 4x4 byte array, column-major. Column c = bytes 4c..4c+3 of the 128-bit word.
- Key expander holds words w0..w3 and an rcon index.
  - On `ld`: w = key, rcon index = 0.
  - Otherwise, each cycle: t = SubWord(RotWord(w3)) ^ {rcon,24'h0}; w0'=w0^t; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'; index++.
  - rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
- Counter `dcnt`:
  - reset → 0.
  - `ld` → 4'hb.
  - else if nonzero → decrement.
  - holds at 0.
- Registered `ld_r` = `ld` delayed one cycle. `text_in_r` captures `text_in` when `ld`=1.
- State register update:
  - if `ld_r`: state = text_in_r ^ w (initial AddRoundKey).
  - else: state = MixColumns(ShiftRows(SubBytes(state))) ^ w.
- ShiftRows: row r rotated left by r columns, i.e. sr[r][c] = sub[r][(c+r) mod 4].
- MixColumns uses xtime(b) = {b[6:0],0} ^ (8'h1b & {8{b[7]}}). Output column = 2a^3b^c^d, a^2b^3c^d, a^b^2c^3d, 3a^b^c^2d.
- `text_out` registers ShiftRows(SubBytes(state)) ^ w every cycle (final round, no MixColumns). It is meaningful only when `done`=1.
- `done` register:
  - if `rst`=1: done = (dcnt==1) & !ld.
  - else: 0.

## Timing
- Reset values: `dcnt`=0, `done`=0, `text_out`=0, `state`=0, key words=0, rcon index=0, `ld_r`=0.
- `ld` sampled at edge E0. Initial AddRoundKey happens at E1. Rounds 1–9 run at E2..E10. Final round and `done`=1 occur at E11, with `done` high for exactly one cycle.
- `ld` during an operation restarts cleanly; the old result is discarded.
- `ld` in the same cycle `dcnt`==1 suppresses `done`.
- Reset mid-operation clears everything; no `done` follows.
- `text_in`/`key` need to be valid only in the `ld` cycle.
- Back-to-back: a new `ld` is accepted in the cycle `done` is high.

## Structure
- Package `aes_pkg`:
  - 256-entry S-box constant array and `sbox()` function.
  - `xtime()` and `mix_col()` functions.
  - rcon table.
  - state typedef `logic [3:0][3:0][7:0]`.
- Natural sub-module: `aes128_key_sched` (w0..w3 registers, rcon, 4 S-box lookups).
- Datapath and counter live in the top level.

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff → `done` at E11, `text_out`=69c4e0d86a7b0430d8cdb78070b4c55a.
- FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 → 3925841d02dc09fbdc118597196a0b32; `state` after E1 = 193de3bea0f4e22b9ac68d2ae9f84808.
- All-zero key and pt → 66e94bd4ef8a2c3b884cfa59ca342b2e.
- Re-`ld` with vector B at dcnt=5 of a C.1 run → single `done` 11 cycles after the second `ld`, with the B ciphertext; no `done` for the aborted run.
- `rst`=0 at dcnt=3 → `dcnt`=0, `done`=0, outputs zero, no later `done`.
- Check `dcnt` sequence b,a,…,1,0 and a one-cycle `done`. `ld` coinciding with dcnt==1 → no `done`.
